// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared constants and types for the 7-segment scan decoder.
//   - Segment bit positions on the active-high pattern (a is the MSB, dp the LSB).
//   - SEG_PAT: pattern displayed for each hex nibble 0..F. The match is exact on all
//     8 bits, so the decimal point distinguishes 8 from B and 0 from D.
//   - SEG_BLANK: all segments off.
//   - seg_dec_t: result of decoding one pattern.
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Idle level of the active-low segment bus, i.e. the blanking gap between digits.
    localparam logic [7:0] SEG_BUS_IDLE = 8'hFF;

    localparam logic [7:0] SEG_PAT [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,   // 0 1 2 3
        8'h66, 8'hB6, 8'hBE, 8'hE0,   // 4 5 6 7
        8'hFE, 8'hF6, 8'hEF, 8'hFF,   // 8 9 A B
        8'h9C, 8'hFD, 8'h9F, 8'h8F    // C D E F
    };

    typedef struct packed {
        logic [3:0] nibble;  // decoded value, 0 when not known
        logic       known;   // pattern is one of SEG_PAT
        logic       blank;   // pattern is SEG_BLANK
    } seg_dec_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
//   Bundles the display-bus inputs and the decoded-value outputs of the scan decoder.
//   master : the side driving the display bus and reading results (display driver or bench)
//   slave  : the decoder itself
//   Signals:
//     seg_n      segment bus, active-low, bit7=a .. bit0=dp
//     dig_sel_n  digit selects, active-low, bit i = digit i
//     clr_err    synchronous pulse clearing pat_err / sel_err
//     hex_val    decoded nibble per digit, digit i at [4i+3:4i]
//     dig_valid  digit i holds a committed known pattern
//     dig_upd    one-cycle pulse on any commit
//     upd_idx    digit index of the commit flagged by dig_upd
//     pat_err    sticky: a digit committed an unknown pattern
//     sel_err    sticky: zero or several selects active while the segment bus was driven
interface seg_scan_decoder_if #(
    parameter int NDIG = 8
);

    logic [7:0]        seg_n;
    logic [NDIG-1:0]   dig_sel_n;
    logic              clr_err;
    logic [4*NDIG-1:0] hex_val;
    logic [NDIG-1:0]   dig_valid;
    logic              dig_upd;
    logic [2:0]        upd_idx;
    logic              pat_err;
    logic              sel_err;

    modport master (
        output seg_n, dig_sel_n, clr_err,
        input  hex_val, dig_valid, dig_upd, upd_idx, pat_err, sel_err
    );

    modport slave (
        input  seg_n, dig_sel_n, clr_err,
        output hex_val, dig_valid, dig_upd, upd_idx, pat_err, sel_err
    );

endinterface

// File: rtl/seg_pat_dec.sv
// seg_pat_dec
//   Combinational decode of an active-high 8-bit segment pattern.
//   Ports:
//     pat  in   8          active-high pattern, bit7=a .. bit0=dp
//     dec  out  seg_dec_t  {nibble, known, blank}
module seg_pat_dec
    import seg_pkg::*;
(
    input  logic [7:0] pat,
    output seg_dec_t   dec
);

    always_comb begin
        // NOTE: every combinational output gets a default before any conditional
        // assignment; otherwise a path that skips the assignment infers a latch.
        dec       = '0;
        dec.blank = (pat == SEG_BLANK);
        // Table entries are unique, so at most one iteration matches.
        for (int k = 0; k < 16; k++) begin
            if (pat == SEG_PAT[k]) begin
                dec.nibble = 4'(k);
                dec.known  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Loopback monitor for a multiplexed 7-segment display. Registers the active-low
//   segment bus and digit selects, tracks a candidate pattern and a run counter per
//   digit, and commits a digit once STABLE_CNT consecutive identical samples were seen
//   while that digit alone was selected. Committed patterns are decoded back to hex.
//   Parameters:
//     NDIG        number of digits (1..8)
//     STABLE_CNT  identical samples needed to commit (2..15)
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    seg_scan_decoder_if.slave (display bus in, decoded values out)
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_decoder_if.slave    bus
);

    localparam logic [3:0] CNT_MAX    = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_COMMIT = 4'(STABLE_CNT - 1);

    // ------------------------------------------------------------------
    // Stage 0: input register. The bus is generated on-chip, so a single
    // register is enough (no synchronizer).
    // ------------------------------------------------------------------
    logic [7:0]      s_seg_q, s_seg_d;
    logic [NDIG-1:0] s_sel_q, s_sel_d;

    always_comb begin
        s_seg_d = bus.seg_n;
        s_sel_d = bus.dig_sel_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state flops use non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            s_seg_q <= SEG_BUS_IDLE;
            s_sel_q <= '1;
        end else begin
            s_seg_q <= s_seg_d;
            s_sel_q <= s_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: shared select check and pattern decode.
    // ------------------------------------------------------------------
    logic [7:0]      pat;
    logic [NDIG-1:0] sel_act;
    logic            one_hot;
    logic [2:0]      sel_idx;
    logic            bus_driven;

    always_comb begin
        pat        = ~s_seg_q;
        sel_act    = ~s_sel_q;
        // Clearing the lowest set bit leaves zero only for a single set bit.
        one_hot    = (sel_act != '0) && ((sel_act & (sel_act - NDIG'(1))) == '0);
        bus_driven = (s_seg_q != SEG_BUS_IDLE);
        sel_idx    = '0;
        // Only meaningful when one_hot; then exactly one iteration fires.
        for (int i = 0; i < NDIG; i++) begin
            if (sel_act[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    seg_dec_t dec;

    seg_pat_dec u_pat_dec (
        .pat (pat),
        .dec (dec)
    );

    // ------------------------------------------------------------------
    // Per-digit candidate pattern and run counter.
    // The counter saturates at STABLE_CNT, so a pattern held indefinitely
    // passes through CNT_COMMIT exactly once and commits once.
    // ------------------------------------------------------------------
    logic [NDIG-1:0] commit_vec;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic [7:0] cand_q, cand_d;
        logic [3:0] cnt_q, cnt_d;
        logic       hit;
        logic       same;

        assign hit  = one_hot && sel_act[i];
        assign same = (pat == cand_q);

        always_comb begin
            cand_d = cand_q;
            cnt_d  = cnt_q;
            if (hit) begin
                if (same) begin
                    if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    // A changed pattern starts a new run; this sample is its first.
                    cand_d = pat;
                    cnt_d  = 4'd1;
                end
            end
        end

        assign commit_vec[i] = hit && same && (cnt_q == CNT_COMMIT);

        // NOTE: these per-digit registers are few and must start from a known
        // candidate/count after reset, so they are reset like any control flop
        // rather than treated as an unreset storage array.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand_q <= SEG_BLANK;
                cnt_q  <= 4'd0;
            end else begin
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit handling and sticky error flags.
    // ------------------------------------------------------------------
    logic [4*NDIG-1:0] hex_val_q, hex_val_d;
    logic [NDIG-1:0]   dig_valid_q, dig_valid_d;
    logic              dig_upd_q, dig_upd_d;
    logic [2:0]        upd_idx_q, upd_idx_d;
    logic              pat_err_q, pat_err_d;
    logic              sel_err_q, sel_err_d;
    logic              commit;

    always_comb begin
        commit      = |commit_vec;
        hex_val_d   = hex_val_q;
        dig_valid_d = dig_valid_q;
        dig_upd_d   = commit;
        upd_idx_d   = upd_idx_q;
        // Clear first, then set: a new error on the same edge as clr_err wins.
        pat_err_d   = pat_err_q & ~bus.clr_err;
        sel_err_d   = sel_err_q & ~bus.clr_err;

        if (commit) begin
            upd_idx_d = sel_idx;
            if (!dec.known && !dec.blank) begin
                pat_err_d = 1'b1;
            end
        end

        for (int i = 0; i < NDIG; i++) begin
            if (commit_vec[i]) begin
                dig_valid_d[i] = dec.known;
                // Blank and unknown patterns keep the last good value.
                if (dec.known) begin
                    hex_val_d[4*i +: 4] = dec.nibble;
                end
            end
        end

        // The blanking gap between digits (no select, bus idle) is legal.
        if (!one_hot && bus_driven) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_val_q   <= '0;
            dig_valid_q <= '0;
            dig_upd_q   <= 1'b0;
            upd_idx_q   <= '0;
            pat_err_q   <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            hex_val_q   <= hex_val_d;
            dig_valid_q <= dig_valid_d;
            dig_upd_q   <= dig_upd_d;
            upd_idx_q   <= upd_idx_d;
            pat_err_q   <= pat_err_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.hex_val   = hex_val_q;
    assign bus.dig_valid = dig_valid_q;
    assign bus.dig_upd   = dig_upd_q;
    assign bus.upd_idx   = upd_idx_q;
    assign bus.pat_err   = pat_err_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder (NDIG=8, STABLE_CNT=4). Inputs change on the
//   falling edge and outputs are read on the falling edge, half a cycle after the
//   rising edge that updated them. A monitor counts dig_upd pulses per digit.
module tb_seg_scan_decoder;

    logic clk;
    logic rst_n;

    seg_scan_decoder_if #(.NDIG(8)) bus ();

    seg_scan_decoder #(
        .NDIG       (8),
        .STABLE_CNT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int upd_total = 0;
    int upd_per [8];
    int base_total;
    int base_per [8];

    // Hand-written active-high patterns for digits 0..7.
    logic [7:0] pats [8] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};

    initial begin
        for (int i = 0; i < 8; i++) upd_per[i] = 0;
    end

    // Counts commit pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.dig_upd === 1'b1) begin
            upd_total++;
            upd_per[bus.upd_idx]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus value for n cycles, ending on a falling edge.
    task automatic cyc(input logic [7:0] seg, input logic [7:0] sel, input int n);
        repeat (n) begin
            bus.seg_n     = seg;
            bus.dig_sel_n = sel;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        cyc(8'hFF, 8'hFF, n);
    endtask

    // Show active-high pattern p on digit d for n cycles.
    task automatic show(input int d, input logic [7:0] p, input int n);
        logic [7:0] sel;
        sel = 8'h01 << d;
        cyc(~p, ~sel, n);
    endtask

    task automatic snap;
        base_total = upd_total;
        for (int i = 0; i < 8; i++) base_per[i] = upd_per[i];
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.seg_n     = 8'hFF;
        bus.dig_sel_n = 8'hFF;
        bus.clr_err   = 1'b0;

        // ---------------- 1: reset ----------------
        repeat (3) @(negedge clk);
        check("rst_hex_val",   bus.hex_val,   32'h0);
        check("rst_dig_valid", bus.dig_valid, 32'h0);
        check("rst_dig_upd",   bus.dig_upd,   32'h0);
        check("rst_upd_idx",   bus.upd_idx,   32'h0);
        check("rst_pat_err",   bus.pat_err,   32'h0);
        check("rst_sel_err",   bus.sel_err,   32'h0);
        rst_n = 1'b1;
        snap();
        idle(4);
        check("idle_no_upd",  upd_total - base_total, 32'd0);
        check("idle_sel_err", bus.sel_err, 32'h0);

        // ---------------- 2: digit 2 shows "2" ----------------
        snap();
        show(2, 8'hDA, 4);
        check("d2_no_upd_before", bus.dig_upd, 32'h0);
        show(2, 8'hDA, 1);
        check("d2_upd_pulse", bus.dig_upd, 32'h1);
        check("d2_upd_idx",   bus.upd_idx, 32'd2);
        check("d2_hex",       bus.hex_val[11:8], 32'h2);
        check("d2_valid",     bus.dig_valid[2], 32'h1);
        show(2, 8'hDA, 1);
        check("d2_upd_one_cycle", bus.dig_upd, 32'h0);
        idle(2);
        check("d2_single_commit", upd_total - base_total, 32'd1);

        // ---------------- 3: dp distinguishes 8/B and 0/D ----------------
        snap();
        show(0, 8'hFE, 3);
        show(0, 8'hFF, 4);
        idle(1);
        check("d0_B_hex",    bus.hex_val[3:0], 32'hB);
        check("d0_B_valid",  bus.dig_valid[0], 32'h1);
        check("d0_B_commits", upd_total - base_total, 32'd1);
        snap();
        show(0, 8'hFC, 3);
        show(0, 8'hFD, 4);
        idle(1);
        check("d0_D_hex",    bus.hex_val[3:0], 32'hD);
        check("d0_D_commits", upd_total - base_total, 32'd1);

        // ---------------- 4: unknown pattern, clr_err ----------------
        snap();
        show(5, 8'h81, 4);
        idle(1);
        check("d5_pat_err",  bus.pat_err, 32'h1);
        check("d5_valid",    bus.dig_valid[5], 32'h0);
        check("d5_upd_idx",  bus.upd_idx, 32'd5);
        check("d5_commits",  upd_total - base_total, 32'd1);
        check("d5_hex_held", bus.hex_val[23:20], 32'h0);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("clr_pat_err", bus.pat_err, 32'h0);
        show(5, 8'h82, 4);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("clr_vs_set_pat_err", bus.pat_err, 32'h1);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("clr_pat_err_2", bus.pat_err, 32'h0);

        // ---------------- 5: select errors ----------------
        snap();
        cyc(8'h03, 8'hFC, 1);          // digits 0 and 1 both selected, bus driven
        show(1, 8'hFC, 3);             // would commit if the bad sample had counted
        idle(1);
        check("sel_err_set",     bus.sel_err, 32'h1);
        check("multi_sel_no_cnt", upd_total - base_total, 32'd0);
        check("d1_still_invalid", bus.dig_valid[1], 32'h0);
        show(1, 8'hFC, 1);
        idle(1);
        check("d1_commit_4th",  upd_total - base_total, 32'd1);
        check("d1_hex",         bus.hex_val[7:4], 32'h0);
        check("d1_valid",       bus.dig_valid[1], 32'h1);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("clr_sel_err", bus.sel_err, 32'h0);
        idle(3);
        check("gap_no_sel_err", bus.sel_err, 32'h0);

        // ---------------- 6: full scan, then reset mid-scan ----------------
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        snap();
        for (int rep = 0; rep < 2; rep++) begin
            for (int d = 0; d < 8; d++) show(d, pats[d], 4);
        end
        idle(1);
        check("scan_commits", upd_total - base_total, 32'd8);
        for (int d = 0; d < 8; d++) begin
            check($sformatf("scan_commits_d%0d", d), upd_per[d] - base_per[d], 32'd1);
        end
        check("scan_hex",   bus.hex_val,   32'h76543210);
        check("scan_valid", bus.dig_valid, 32'hFF);
        check("scan_errs",  {bus.pat_err, bus.sel_err}, 32'h0);

        show(0, pats[0], 4);
        show(1, pats[1], 2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.dig_valid, 32'h0);
        check("midrst_hex",   bus.hex_val,   32'h0);
        @(negedge clk);
        show(2, pats[2], 2);
        rst_n = 1'b1;
        snap();
        show(3, pats[3], 3);
        show(4, pats[4], 4);
        idle(1);
        check("post_rst_commits", upd_total - base_total, 32'd1);
        check("post_rst_idx",     bus.upd_idx, 32'd4);
        check("post_rst_hex",     bus.hex_val[19:16], 32'h4);
        check("post_rst_valid",   bus.dig_valid, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
